// File: rtl/prio_irq_ctrl_if.sv
// rtl/prio_irq_ctrl_if.sv - grant handshake between the controller and its consumer
interface prio_irq_ctrl_if;
  logic       irq_valid;
  logic [2:0] irq_code;
  logic       irq_ack;

  modport master (output irq_valid, output irq_code, input irq_ack);
  modport slave  (input irq_valid, input irq_code, output irq_ack);
endinterface

// File: rtl/prio_irq_ctrl.sv
// rtl/prio_irq_ctrl.sv - pending capture, masking and fixed-priority grant of eight request lines
module prio_irq_ctrl #(
  parameter bit EDGE_MODE = 1'b1,
  parameter int N_REQ     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_in,
  input  logic [N_REQ-1:0]     mask,
  input  logic                 ovf_clr,
  output logic [N_REQ-1:0]     pending,
  output logic                 overflow,
  prio_irq_ctrl_if.master      irq
);

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_PRESENT = 1'b1;

  logic [0:0]       state;
  logic [N_REQ-1:0] req_q;
  logic [N_REQ-1:0] evt;
  logic [N_REQ-1:0] clr;
  logic [N_REQ-1:0] eligible;
  logic [2:0]       enc_code;

  always_comb begin
    evt = EDGE_MODE ? (req_in & ~req_q) : req_in;
    clr = '0;
    if (irq.irq_valid && irq.irq_ack)
      clr = {{(N_REQ-1){1'b0}}, 1'b1} << (3'd7 - irq.irq_code);
    eligible = pending & mask;
  end

  // Ascending scan so the highest eligible line is the last assignment to win.
  always_comb begin
    enc_code = '0;
    for (int k = 0; k < N_REQ; k++)
      if (eligible[k]) enc_code = 3'(N_REQ - 1 - k);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q         <= '0;
      pending       <= '0;
      overflow      <= 1'b0;
      irq.irq_valid <= 1'b0;
      irq.irq_code  <= '0;
      state         <= S_IDLE;
    end else begin
      req_q   <= req_in;
      pending <= (pending & ~clr) | evt;
      if (|(evt & pending & ~clr))
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;

      case (state)
        S_IDLE: begin
          if (|eligible) begin
            irq.irq_code  <= enc_code;
            irq.irq_valid <= 1'b1;
            state         <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (irq.irq_ack) begin
            irq.irq_valid <= 1'b0;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prio_irq_ctrl.sv
// tb/tb_prio_irq_ctrl.sv - scoreboard bench for prio_irq_ctrl against a line-level reference model
module tb_prio_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req_in = '0;
  logic [7:0] mask = 8'hFF;
  logic       ovf_clr = 1'b0;
  logic [7:0] pending;
  logic       overflow;

  prio_irq_ctrl_if irq_bus ();

  prio_irq_ctrl #(.EDGE_MODE(1'b1), .N_REQ(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_in   (req_in),
    .mask     (mask),
    .ovf_clr  (ovf_clr),
    .pending  (pending),
    .overflow (overflow),
    .irq      (irq_bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: a set of pending lines, one outstanding grant identified by line number.
  bit         m_pend [8];
  bit         m_prev [8];
  bit         m_valid;
  int         m_line;
  bit         m_ovf;
  logic [2:0] exp_q [$];

  always @(posedge clk) begin
    bit ev [8];
    bit nxt [8];
    int cl;
    int hi;
    bit ovs;
    if (rst) begin
      foreach (m_pend[k]) begin m_pend[k] = 0; m_prev[k] = 0; end
      m_valid = 0;
      m_line  = 0;
      m_ovf   = 0;
      exp_q.delete();
    end else begin
      cl  = (m_valid && irq_bus.irq_ack) ? m_line : -1;
      ovs = 0;
      for (int k = 0; k < 8; k++) begin
        ev[k]  = req_in[k] && !m_prev[k];
        nxt[k] = m_pend[k];
        if (k == cl) nxt[k] = 0;
        if (ev[k]) begin
          if (m_pend[k] && k != cl) ovs = 1;
          nxt[k] = 1;
        end
      end
      if (!m_valid) begin
        hi = -1;
        for (int k = 7; k >= 0; k--)
          if (hi < 0 && m_pend[k] && mask[k]) hi = k;
        if (hi >= 0) begin
          m_valid = 1;
          m_line  = hi;
          exp_q.push_back(3'(7 - hi));
        end
      end else if (irq_bus.irq_ack) begin
        m_valid = 0;
      end
      if (ovs) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
      for (int k = 0; k < 8; k++) begin
        m_pend[k] = nxt[k];
        m_prev[k] = req_in[k];
      end
    end
  end

  // Monitor: compares state every cycle and pops the scoreboard on each new grant.
  bit         mon_en = 0;
  bit         prev_valid = 0;
  logic [2:0] prev_code = '0;

  always @(negedge clk) begin
    logic [7:0] mp;
    logic [2:0] exp_code;
    if (mon_en) begin
      for (int k = 0; k < 8; k++) mp[k] = m_pend[k];
      chk("pending", pending, mp);
      chk("overflow", overflow, m_ovf);
      chk("irq_valid", irq_bus.irq_valid, m_valid);
      if (irq_bus.irq_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_grant", 1, 0);
        end else begin
          exp_code = exp_q.pop_front();
          chk("grant_code", irq_bus.irq_code, exp_code);
        end
      end else if (irq_bus.irq_valid && prev_valid) begin
        chk("code_held", irq_bus.irq_code, prev_code);
      end
      prev_valid = irq_bus.irq_valid;
      prev_code  = irq_bus.irq_code;
    end
  end

  bit auto_ack = 0;
  int ack_pct  = 100;

  task automatic tick();
    @(negedge clk);
    if (auto_ack)
      irq_bus.irq_ack = irq_bus.irq_valid && ($urandom_range(99) < ack_pct);
  endtask

  initial begin
    irq_bus.irq_ack = 1'b0;
    rst = 1'b1;
    tick(); tick();
    chk("rst_pending", pending, 8'h00);
    chk("rst_valid", irq_bus.irq_valid, 0);
    chk("rst_code", irq_bus.irq_code, 3'b000);
    chk("rst_overflow", overflow, 0);
    mon_en = 1;

    // Single event on line 2
    rst = 1'b0; req_in = 8'b0000_0100;
    tick();
    chk("single_pending", pending, 8'h04);
    tick();
    chk("single_valid", irq_bus.irq_valid, 1);
    chk("single_code", irq_bus.irq_code, 3'b101);
    irq_bus.irq_ack = 1'b1;
    tick();
    irq_bus.irq_ack = 1'b0;
    chk("single_cleared", pending, 8'h00);
    req_in = 8'h00;
    tick();

    // Three simultaneous lines, acknowledged immediately
    auto_ack = 1; ack_pct = 100;
    req_in = 8'b1001_0001;
    repeat (8) tick();
    chk("prio_drained", pending, 8'h00);
    req_in = 8'h00;
    tick();

    // No preemption by a higher line while a grant is outstanding
    auto_ack = 0; irq_bus.irq_ack = 1'b0;
    req_in = 8'h01;
    tick(); tick();
    chk("nopre_code0", irq_bus.irq_code, 3'b111);
    req_in = 8'h81;
    repeat (3) tick();
    chk("nopre_valid", irq_bus.irq_valid, 1);
    chk("nopre_code1", irq_bus.irq_code, 3'b111);
    irq_bus.irq_ack = 1'b1;
    tick();
    irq_bus.irq_ack = 1'b0;
    tick();
    chk("nopre_next", irq_bus.irq_code, 3'b000);
    irq_bus.irq_ack = 1'b1;
    tick();
    irq_bus.irq_ack = 1'b0; req_in = 8'h00;
    tick();

    // Masked line stays pending until unmasked
    auto_ack = 1; mask = 8'h7F;
    req_in = 8'h88;
    repeat (6) tick();
    chk("mask_pending", pending, 8'h80);
    chk("mask_idle", irq_bus.irq_valid, 0);
    mask = 8'hFF;
    repeat (4) tick();
    chk("unmask_drained", pending, 8'h00);
    req_in = 8'h00;
    tick();

    // Overflow, event-wins-over-clear, set-wins-over-clear
    auto_ack = 0; irq_bus.irq_ack = 1'b0;
    req_in = 8'h20;
    tick(); tick();
    req_in = 8'h00; tick();
    req_in = 8'h20; tick();
    chk("ovf_set", overflow, 1);
    req_in = 8'h00; ovf_clr = 1'b1; tick();
    ovf_clr = 1'b0;
    chk("ovf_cleared", overflow, 0);
    req_in = 8'h20; irq_bus.irq_ack = 1'b1; tick();
    irq_bus.irq_ack = 1'b0;
    chk("evt_wins_pending", pending, 8'h20);
    chk("evt_wins_no_ovf", overflow, 0);
    req_in = 8'h00; tick();
    req_in = 8'h20; ovf_clr = 1'b1; tick();
    ovf_clr = 1'b0;
    chk("ovf_set_wins", overflow, 1);
    req_in = 8'h00; irq_bus.irq_ack = 1'b1; tick();
    irq_bus.irq_ack = 1'b0; tick();

    // Reset while a grant is outstanding and every line pending
    req_in = 8'hFF;
    tick(); tick();
    chk("pre_rst_pending", pending, 8'hFF);
    rst = 1'b1;
    tick();
    chk("midrst_valid", irq_bus.irq_valid, 0);
    chk("midrst_pending", pending, 8'h00);
    chk("midrst_code", irq_bus.irq_code, 3'b000);
    chk("midrst_overflow", overflow, 0);
    rst = 1'b0; req_in = 8'h00;
    tick();

    // Randomized traffic
    auto_ack = 1; ack_pct = 60;
    for (int i = 0; i < 3000; i++) begin
      tick();
      req_in  = 8'($urandom) & 8'($urandom);
      mask    = ($urandom_range(3) == 0) ? 8'($urandom) : 8'hFF;
      ovf_clr = ($urandom_range(19) == 0);
      rst     = ($urandom_range(499) == 0);
    end
    rst = 1'b0; req_in = 8'h00; mask = 8'hFF; ovf_clr = 1'b0;
    repeat (30) tick();
    chk("sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
